alu_result_fifo: RTL



---
 rtl/alu_pkg.sv | 13 +
 rtl/fifo_mem.sv | 24 ++
 rtl/alu_result_fifo.sv | 75 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU and its downstream result FIFO.
package alu_pkg;

  localparam int ALU_N = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR  = 2'b01,
    ALU_AND = 2'b10,
    ALU_CAT = 2'b11
  } alu_func_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the result FIFO: one write port, one asynchronous read port.
module fifo_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Buffers 2N-bit ALU results in a first-word-fall-through FIFO, tracks the last
// accepted result and a sticky flag for results lost to a full FIFO.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [2*N-1:0]           InData,
  input  logic                     InValid,
  output logic                     InReady,
  output logic [2*N-1:0]           OutData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [2*N-1:0]           LastResult,
  output logic                     Dropped,
  input  logic                     ClearDrop
);

  localparam int W  = 2 * N;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr, rptr;
  logic          push, pop, drop;

  // A transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the other side's valid or ready in the same cycle.
  assign InReady  = (Count != CW'(DEPTH));
  assign OutValid = (Count != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;
  assign drop     = InValid && !InReady;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      Count      <= '0;
      LastResult <= '0;
      Dropped    <= 1'b0;
    end else begin
      if (push) begin
        wptr       <= wptr + PW'(1);
        LastResult <= InData;
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
      // A drop in the same cycle as ClearDrop keeps the flag set.
      if (drop)           Dropped <= 1'b1;
      else if (ClearDrop) Dropped <= 1'b0;
    end
  end

  fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (Clock),
    .we    (push),
    .waddr (wptr),
    .wdata (InData),
    .raddr (rptr),
    .rdata (OutData)
  );

endmodule
